// File: rtl/nt35510_bus_responder.sv
// NT35510-style 8080 LCD bus responder: oversampled bus decode, 4-entry parameter file,
// register readback and a FWFT pixel FIFO. Readback path built only with NT35510_RESP_READBACK_EN.
module nt35510_bus_responder #(
  parameter int unsigned FIFO_DEPTH = 16,  // power of two, >= 2
  parameter logic [15:0] ID0        = 16'h0080,
  parameter logic [15:0] ID1        = 16'h0055,
  parameter logic [15:0] ID2        = 16'h0010
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        LCD_csel,
  input  logic        LCD_rs,
  input  logic        LCD_wr,
  input  logic        LCD_rd,
  input  logic [15:0] LCD_data_in,
  output logic [15:0] LCD_data_out,
  output logic        LCD_data_oe,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        overflow,
  output logic [7:0]  cur_cmd
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  CMD_SWRESET = 8'h01;
  localparam logic [7:0]  CMD_RDDID   = 8'h04;
  localparam logic [7:0]  CMD_RAMWR   = 8'h2C;
  localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};

  // ---------------- synchronizers ----------------
  logic [1:0]  csel_sync_q, rs_sync_q, wr_sync_q;
  logic        wr_dly_q;
  logic [15:0] data_sync1_q, data_sync2_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  // Strobes and chip select reset to their idle-high level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      csel_sync_q  <= 2'b11;
      rs_sync_q    <= 2'b00;
      wr_sync_q    <= 2'b11;
      wr_dly_q     <= 1'b1;
      data_sync1_q <= '0;
      data_sync2_q <= '0;
    end else begin
      csel_sync_q  <= {csel_sync_q[0], LCD_csel};
      rs_sync_q    <= {rs_sync_q[0], LCD_rs};
      wr_sync_q    <= {wr_sync_q[0], LCD_wr};
      wr_dly_q     <= wr_sync_q[1];
      data_sync1_q <= LCD_data_in;
      data_sync2_q <= data_sync1_q;
    end
  end

  logic        csel_s, rs_s, wr_s, bus_sel, wr_rise, cmd_wr, dat_wr;
  logic [15:0] data_s;
  assign csel_s  = csel_sync_q[1];
  assign rs_s    = rs_sync_q[1];
  assign wr_s    = wr_sync_q[1];
  assign data_s  = data_sync2_q;
  assign bus_sel = ~csel_s;
  assign wr_rise = bus_sel & wr_s & ~wr_dly_q;
  assign cmd_wr  = wr_rise & ~rs_s;
  assign dat_wr  = wr_rise & rs_s;

  // ---------------- state ----------------
  logic [7:0]       cur_cmd_q, cur_cmd_d;
  logic [3:0][15:0] param_q, param_d;
  logic [1:0]       idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic             push_q, push_d;
  logic [15:0]      push_data_q, push_data_d;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic             empty, full, pop, push_ok, idx_step_rd;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = ~empty & pix_ready;
  assign push_ok = push_q & (~full | pop);

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    cur_cmd_d   = cur_cmd_q;
    param_d     = param_q;
    idx_d       = idx_q;
    overflow_d  = overflow_q;
    push_d      = 1'b0;
    push_data_d = data_s;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (pop)               rptr_d     = rptr_q + PTR_ONE;
    if (push_ok)           wptr_d     = wptr_q + PTR_ONE;
    if (push_q & ~push_ok) overflow_d = 1'b1;
    if (cmd_wr) begin
      cur_cmd_d = data_s[7:0];
      idx_d     = 2'd0;
      if (data_s[7:0] == CMD_SWRESET) begin
        param_d    = '0;
        wptr_d     = '0;
        rptr_d     = '0;
        overflow_d = 1'b0;
      end
      if (data_s[7:0] == CMD_RAMWR) overflow_d = 1'b0;
    end else if (dat_wr) begin
      if (cur_cmd_q == CMD_RAMWR) begin
        push_d = 1'b1;
      end else begin
        param_d[idx_q] = data_s;
        if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
      end
    end else if (idx_step_rd && idx_q != 2'd3) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_cmd_q   <= '0;
      param_q     <= '0;
      idx_q       <= '0;
      overflow_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      cur_cmd_q   <= cur_cmd_d;
      param_q     <= param_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; pointers define validity and pix_data is gated.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_q;
  end

  assign pix_valid = ~empty;
  assign pix_data  = empty ? 16'h0000 : mem_q[rptr_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign cur_cmd   = cur_cmd_q;

  // ---------------- read path ----------------
`ifdef NT35510_RESP_READBACK_EN
  logic [1:0]  rd_sync_q;
  logic        rd_dly_q, csel_dly_q;
  logic [15:0] rdata_q, rdata_d;
  logic        oe_q, oe_d, rd_param_q, rd_param_d;
  logic        rd_s, rd_fall, rd_done;

  assign rd_s        = rd_sync_q[1];
  assign rd_fall     = bus_sel & ~rd_s & rd_dly_q;
  // csel rising ends a read even if rd is still low.
  assign rd_done     = oe_q & ((rd_s & ~rd_dly_q) | (csel_s & ~csel_dly_q));
  assign idx_step_rd = rd_done & rd_param_q;

  always_comb begin
    rdata_d    = rdata_q;
    oe_d       = oe_q;
    rd_param_d = rd_param_q;
    if (rd_fall) begin
      oe_d       = 1'b1;
      rd_param_d = rs_s & wr_s;
      if (!rs_s || !wr_s) begin
        rdata_d = 16'h0000;
      end else if (cur_cmd_q == CMD_RDDID) begin
        case (idx_q)
          2'd0:    rdata_d = ID0;
          2'd1:    rdata_d = ID1;
          2'd2:    rdata_d = ID2;
          default: rdata_d = 16'h0000;
        endcase
      end else begin
        rdata_d = param_q[idx_q];
      end
    end else if (rd_done) begin
      oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_sync_q  <= 2'b11;
      rd_dly_q   <= 1'b1;
      csel_dly_q <= 1'b1;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
      rd_param_q <= 1'b0;
    end else begin
      rd_sync_q  <= {rd_sync_q[0], LCD_rd};
      rd_dly_q   <= rd_sync_q[1];
      csel_dly_q <= csel_s;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
      rd_param_q <= rd_param_d;
    end
  end

  assign LCD_data_out = rdata_q;
  assign LCD_data_oe  = oe_q;
`else
  logic        unused_rd;
  logic [47:0] unused_ids;
  assign unused_rd    = LCD_rd;
  assign unused_ids   = {ID0, ID1, ID2};
  assign idx_step_rd  = 1'b0;
  assign LCD_data_out = 16'h0000;
  assign LCD_data_oe  = 1'b0;
`endif

endmodule

// File: doc/nt35510_bus_responder.md
# nt35510_bus_responder

Synthesizable responder for the NT35510-style 8080 parallel LCD bus, the far end of the LCD bus that our APB LCD adapter drives. It oversamples the bus in the system clock, decodes command and parameter writes, keeps a small parameter register file, serves register reads, and forwards RAMWR pixel data to a valid/ready stream through a FIFO. It is used both as an on-chip frame sink and as a loopback target for bring-up of the LCD path.

## Interface
- FIFO_DEPTH, 16: pixel FIFO entries; must be a power of two, minimum 2.
- ID0 / ID1 / ID2, 16'h0080 / 16'h0055 / 16'h0010: words returned by RDDID (0x04).
- clk  input  1  system clock; all logic is in this domain.
- nrst  input  1  asynchronous, active-low reset.
- LCD_csel  input  1  chip select, active low.
- LCD_rs  input  1  0 = command, 1 = data/parameter.
- LCD_wr  input  1  write strobe, active low; data is captured on its rising edge.
- LCD_rd  input  1  read strobe, active low.
- LCD_data_in  input  16  bus data driven by the host.
- LCD_data_out  output  16  read data driven back to the host.
- LCD_data_oe  output  1  1 = the responder drives LCD_data_out.
- pix_valid  output  1  pixel stream valid.
- pix_ready  input  1  pixel stream ready.
- pix_data  output  16  pixel word.
- overflow  output  1  sticky flag: a pixel was dropped because the FIFO was full.
- cur_cmd  output  8  last command byte received.

## Operation
- Synchronizers: csel, rs, wr, rd and data[15:0] each pass through 2 flops. Edges are detected on the synchronized wr and rd against a third delayed copy.
- A bus event is qualified only while the synchronized csel = 0. Strobes seen with csel = 1 are ignored.
- Command write (wr rising, rs = 0):
  - cur_cmd <= data[7:0] and param_idx <= 0.
  - 0x01 (SWRESET) clears the parameter registers, flushes the FIFO and clears overflow.
  - 0x2C (RAMWR) clears overflow.
- Data write (wr rising, rs = 1):
  - If cur_cmd = 0x2C, the word is pushed to the FIFO. If the FIFO is full the word is dropped and overflow <= 1.
  - Otherwise param[param_idx] <= data and param_idx increments, saturating at 3. The register file holds 4 × 16-bit entries.
- Read (rd falling, rs = 1):
  - The read register is loaded: ID0/ID1/ID2 indexed by param_idx when cur_cmd = 0x04 (index 3 returns 0), otherwise param[param_idx].
  - LCD_data_oe <= 1.
  - On rd rising, or when csel rises, LCD_data_oe <= 0 and param_idx increments, saturating at 3.
- A read with rs = 0 returns 0x0000 with oe asserted.
- Simultaneous wr and rd low is illegal. If it occurs, the write takes effect and the read returns 0x0000.
- FIFO behaviour:
  - Standard first-word-fall-through.
  - pix_valid = not empty.
  - A pop happens on pix_valid & pix_ready.
  - Push and pop in the same cycle while full: the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

## Timing
- Reset values: LCD_data_out = 0, LCD_data_oe = 0, pix_valid = 0, pix_data = 0, overflow = 0, cur_cmd = 0x00. Params, param_idx and FIFO pointers also clear to 0.
- An asserted nrst mid-transfer aborts the transfer immediately. No partial write is retained.
- Write latency: the register or FIFO update is visible 3 clk after the wr rising edge at the pin. A pushed pixel appears on pix_valid 4 clk after the edge.
- Read latency: LCD_data_out is valid and oe = 1 within 4 clk of the rd falling edge at the pin. oe drops within 4 clk of rd or csel rising.
- Minimum strobe low and high widths are 3 clk each. Data must be stable from wr falling until 3 clk after wr rising. Our adapter (10-cycle write, 100-cycle read) meets both.

## Configuration
- NT35510_RESP_READBACK_EN
  - Defined: the read path is present as described above.
  - Undefined: the read logic and ID parameters are removed, LCD_data_oe is tied 0 and LCD_data_out is tied 0. rd strobes do not advance param_idx.

## Test plan
- Write cmd 0x36, then data 0x0048 and 0x0011, then read twice after re-issuing cmd 0x36 → param0 = 0x0048, param1 = 0x0011; reads return 0x0048 then 0x0011, and oe pulses once per read.
- Cmd 0x04, then 4 reads → returns 0x0080, 0x0055, 0x0010, 0x0000.
- Cmd 0x2C, then data 0x1234, 0xABCD, 0xF00F with pix_ready = 1 → the stream emits those three words in order; overflow = 0.
- FIFO_DEPTH = 4, pix_ready = 0, cmd 0x2C, then 6 data writes → 4 words are held and overflow = 1. Releasing pix_ready yields the first 4 words only.
- A wr pulse with csel = 1 carrying 0x0001 → no state change. Cmd 0x01 after stored params and FIFO data → params = 0, FIFO empty, overflow = 0.
- nrst asserted during an active read (oe = 1) → oe = 0 asynchronously, and all outputs return to their reset values.
